vector_mem_stage: RTL

Memory-access stage of the vector CPU pipeline, between the EX/MEM pipeline register and `segment_mem_wb`. It serialises an R-lane vector load or store onto a single N-bit-wide data-memory port and stalls the front of the pipeline for the duration. For loads it assembles `ReadDataM` for the MEM/WB register.

---
 rtl/vector_mem_stage.sv | 109 ++++++++++
 1 files changed

// File: rtl/vector_mem_stage.sv
// Memory-access stage: serialises an R-lane vector load/store onto one N-bit
// memory port, stalling the upstream pipeline until the transfer completes.
module vector_mem_stage #(
  parameter int I = 32,
  parameter int N = 8,
  parameter int R = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemReadM,
  input  logic                MemWriteM,
  input  logic [I-1:0]        AddrM,
  input  logic [R-1:0][N-1:0] WriteDataM,
  input  logic [N-1:0]        MemRD,
  output logic [I-1:0]        MemAddr,
  output logic [N-1:0]        MemWD,
  output logic                MemWE,
  output logic [R-1:0][N-1:0] ReadDataM,
  output logic                StallM
);

  // state | meaning
  // IDLE  | no transfer; a request here issues lane 0 and starts stalling
  // LOAD  | address lane idx issued, data for lane idx-1 captured
  // STORE | lane idx written
  // DONE  | one non-stalled cycle with the result stable, then back to IDLE

  localparam int IW = $clog2(R + 1);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          we_raw;
  logic          capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      ReadDataM <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      // Memory data arrives one cycle late, so it belongs to the previous lane.
      if (capture) ReadDataM[idx - IW'(1)] <= MemRD;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    StallM    = 1'b0;
    we_raw    = 1'b0;
    capture   = 1'b0;
    MemAddr   = AddrM + I'(idx);
    MemWD     = '0;

    unique case (state)
      IDLE: begin
        MemAddr = AddrM;
        idx_nxt = '0;
        if (MemWriteM) begin
          StallM    = 1'b1;
          we_raw    = 1'b1;
          MemWD     = WriteDataM[0];
          state_nxt = STORE;
          idx_nxt   = IW'(1);
        end else if (MemReadM) begin
          StallM    = 1'b1;
          state_nxt = LOAD;
          idx_nxt   = IW'(1);
        end
      end
      STORE: begin
        StallM = 1'b1;
        we_raw = 1'b1;
        MemWD  = WriteDataM[idx];
        if (idx == IW'(R - 1)) begin
          state_nxt = DONE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + IW'(1);
        end
      end
      LOAD: begin
        StallM  = 1'b1;
        capture = 1'b1;
        if (idx == IW'(R)) begin
          state_nxt = DONE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + IW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  assign MemWE = we_raw & ~reset;

endmodule
